// File: rtl/cornet_bus_unit.sv
// Cornet bus master: one engine serving instruction fetch and data clients over a shared
// 8-bit memory bus, with data-over-fetch priority, little-endian multi-beat transfers and beat timeout.
module cornet_bus_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_BYTES  = 4,
  parameter int unsigned LEN_WIDTH  = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_valid,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic                   fetch_done,
  output logic [7:0]             fetch_data,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [LEN_WIDTH-1:0]   req_len,
  input  logic [8*MAX_BYTES-1:0] req_wdata,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic [8*MAX_BYTES-1:0] resp_rdata,
  output logic                   resp_err,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   rd_req,
  output logic                   wr_en,
  output logic [7:0]             wr_data,
  input  logic [7:0]             rd_data,
  input  logic                   ready
);
  localparam int unsigned          DW       = 8 * MAX_BYTES;
  localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(MAX_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t                state_q;
  state_t                state_next;
  logic                  client_fetch_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic [DW-1:0]         wdata_q;
  logic [DW-1:0]         rbuf_q;
  logic [DW-1:0]         rbuf_next;
  logic [7:0]            wbyte_next;
  logic [15:0]           tcount_q;
  logic                  accept;
  logic                  last_beat;
  logic                  beat_adv;
  logic                  finish;
  logic                  timed_out;

  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_ready | fetch_ready;
  assign last_beat = (beat_q == len_q - 1'b1);

  always_comb begin
    if (req_len == '0)
      eff_len = LEN_WIDTH'(1);
    else if (req_len > LEN_MAX)
      eff_len = LEN_MAX;
    else
      eff_len = req_len;
  end

  // Accumulator with the current beat's byte merged, and the byte for the following beat.
  always_comb begin
    rbuf_next  = rbuf_q;
    wbyte_next = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i == 32'(beat_q))
        rbuf_next[8*i +: 8] = rd_data;
      if (i == 32'(beat_q) + 32'd1)
        wbyte_next = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_next;
  end

  always_comb begin
    state_next  = state_q;
    req_ready   = 1'b0;
    fetch_ready = 1'b0;
    beat_adv    = 1'b0;
    finish      = 1'b0;
    timed_out   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready   = req_valid;
        fetch_ready = fetch_valid & ~req_valid;
        if (req_valid | fetch_valid)
          state_next = ST_ISSUE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (ready) begin
          if (last_beat) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            beat_adv   = 1'b1;
            state_next = ST_ISSUE;
          end
        end else if (tcount_q == TMO_LAST) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus strobes are launched on the edge entering ISSUE so they are visible for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      client_fetch_q <= 1'b0;
      write_q        <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      beat_q         <= '0;
      wdata_q        <= '0;
      rbuf_q         <= '0;
      tcount_q       <= '0;
      addr           <= '0;
      rd_req         <= 1'b0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      fetch_done     <= 1'b0;
      fetch_data     <= '0;
    end else begin
      rd_req     <= 1'b0;
      wr_en      <= 1'b0;
      resp_valid <= 1'b0;
      fetch_done <= 1'b0;
      resp_err   <= 1'b0;

      if (accept) begin
        client_fetch_q <= fetch_ready;
        write_q        <= req_ready & req_write;
        base_q         <= req_ready ? req_addr : fetch_addr;
        len_q          <= req_ready ? eff_len : LEN_WIDTH'(1);
        wdata_q        <= req_wdata;
        rbuf_q         <= '0;
        beat_q         <= '0;
        addr           <= req_ready ? req_addr : fetch_addr;
        if (req_ready & req_write) begin
          wr_en   <= 1'b1;
          wr_data <= req_wdata[7:0];
        end else begin
          rd_req <= 1'b1;
        end
      end

      if (state_q == ST_ISSUE)
        tcount_q <= '0;

      if (state_q == ST_WAIT) begin
        if (ready && !write_q)
          rbuf_q <= rbuf_next;
        if (!ready)
          tcount_q <= tcount_q + 16'd1;
      end

      if (beat_adv) begin
        beat_q <= beat_q + 1'b1;
        addr   <= base_q + ADDR_WIDTH'(beat_q + 1'b1);
        if (write_q) begin
          wr_en   <= 1'b1;
          wr_data <= wbyte_next;
        end else begin
          rd_req <= 1'b1;
        end
      end

      if (finish) begin
        resp_err <= timed_out;
        if (client_fetch_q) begin
          fetch_done <= 1'b1;
          fetch_data <= timed_out ? 8'h00 : rd_data;
        end else begin
          resp_valid <= 1'b1;
          if (!write_q)
            resp_rdata <= timed_out ? rbuf_q : rbuf_next;
        end
      end
    end
  end

endmodule
